lcd_text_buffer: RTL and testbench
==================================

# lcd_text_buffer

Parametrised single-clock character buffer for the LCD path: holds ROWS×COLS display cells, and accepts commands from the processor side. Commands are positional write, write-at-cursor with auto-advance, cursor set and home, multi-cycle clear, and a one-line scroll-up. The LCD controller reads cells through an independent registered read port, which stays live during sweeps. It succeeds the fixed 32-cell two-clock LCD RAM, generalising geometry and adding cursor and scroll behaviour.

## Interface
- DATA_WIDTH, 8, cell width in bits
- COLS, 16, cells per row
- ROWS, 2, number of rows; DEPTH = COLS*ROWS
- POS_BITS, 5, position width; DEPTH <= 2**POS_BITS is required
- BLANK, 8'h20, fill value (truncated/zero-extended to DATA_WIDTH)
- AUTO_SCROLL, 0, 1 = cursor overflow scrolls instead of wrapping

- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  command strobe
- cmd  in  3  0 NOP, 1 WRITE_AT, 2 WRITE_CUR, 3 SET_CUR, 4 CLEAR, 5 SCROLL, 6 HOME, 7 NOP
- pos  in  POS_BITS  target position for WRITE_AT / SET_CUR
- data  in  DATA_WIDTH  write data for WRITE_AT / WRITE_CUR
- cmd_ready  out  1  equals !busy (combinational)
- busy  out  1  sweep in progress
- cursor  out  POS_BITS  current cursor
- rd_pos  in  POS_BITS  LCD-side read address
- rd_data  out  DATA_WIDTH  registered read data

## Operation
- Storage is a register array of DEPTH cells. Position p maps to row p/COLS, column p%COLS.
- A command is accepted on a rising edge when cmd_valid && !busy. Commands presented while busy are dropped; there is no queue.
- WRITE_AT: if pos < DEPTH, mem[pos] <= data and cursor <= pos+1, with overflow handled as for WRITE_CUR. If pos >= DEPTH, the command is ignored.
- WRITE_CUR: mem[cursor] <= data, then the cursor advances.
- Cursor overflow (advance from DEPTH-1):
  - AUTO_SCROLL=0: cursor <= 0.
  - AUTO_SCROLL=1: a SCROLL sweep starts on the next cycle and cursor <= (ROWS-1)*COLS.
- SET_CUR: cursor <= pos if pos < DEPTH; otherwise the command is ignored. HOME: cursor <= 0.
- CLEAR: cursor <= 0, then enter the CLR sweep.
- SCROLL: cursor unchanged, then enter the SCR_COPY sweep.
- FSM states IDLE, CLR, SCR_COPY, SCR_FILL. A sweep index idx is POS_BITS wide.
  - CLR: mem[idx] <= BLANK for idx = 0..DEPTH-1, then IDLE.
  - SCR_COPY: mem[idx] <= mem[idx+COLS] for idx = 0..DEPTH-COLS-1, then SCR_FILL.
  - SCR_FILL: mem[idx] <= BLANK for idx = DEPTH-COLS..DEPTH-1, then IDLE.
  - With ROWS=1, SCROLL goes straight to SCR_FILL.
- Read port: rd_data <= (rd_pos < DEPTH) ? mem[rd_pos] : BLANK every cycle, including during sweeps. A read sees the pre-edge contents, so a same-cycle write to the same cell returns old data.
- Async reset: state <= CLR, idx <= 0, cursor <= 0, rd_data <= BLANK. Memory is not reset directly; the clear sweep runs on release. Reset mid-sweep abandons the sweep and restarts the clear.

## Timing
- Reset values:
  - busy = 1, cmd_ready = 0, cursor = 0, rd_data = BLANK.
  - After release, busy stays high for exactly DEPTH rising edges.
- WRITE_AT / WRITE_CUR / SET_CUR / HOME: single cycle. The cursor update is visible the cycle after acceptance.
- Read latency: 1 cycle from rd_pos to rd_data.
- Write visibility: a write accepted at edge N, read with rd_pos presented after N, gives the new data on rd_data after edge N+1.
- CLEAR:
  - busy rises the cycle after acceptance and stays high for DEPTH cycles.
  - One cell is written per cycle.
  - cmd_ready returns high in the cycle after the last cell is written.
- SCROLL: busy for DEPTH cycles (DEPTH-COLS copy cycles, then COLS fill cycles). Auto-scroll adds one IDLE cycle before SCR_COPY, during which busy = 1.
- Simultaneous reset and command: reset wins.
- idx saturates at its terminal value and never wraps within a sweep.

## Test plan
- Reset release -> busy=1 for 32 cycles, cursor=0. Then read positions 0..31 -> all 0x20.
- WRITE_AT pos=5 data=0x41 -> cursor=6; read rd_pos=5 -> 0x41 one cycle later. Same-cycle read of pos 5 during the write -> 0x20.
- SET_CUR 30, WRITE_CUR 0x58, WRITE_CUR 0x59 (AUTO_SCROLL=0) -> mem[30]=0x58, mem[31]=0x59, cursor=0, busy never asserted.
- AUTO_SCROLL=1: write 0x41 to cells 0..15 and 0x42 to cells 16..31 via WRITE_CUR -> the last write triggers a scroll with busy high for 33 cycles. Afterwards cells 0..15 = 0x42, cells 16..31 = 0x20, cursor=16.
- CLEAR accepted, then WRITE_AT pos=3 data=0x55 while busy -> write dropped, cmd_ready=0; after the sweep mem[3]=0x20, cursor=0.
- Reset asserted mid-SCROLL (10th copy cycle) -> sweep abandoned, clear restarts. All 32 cells = 0x20 after 32 cycles, cursor=0; rd_pos=40 returns 0x20 throughout.

Source files
------------

// File: rtl/lcd_text_buffer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_text_buffer
// Brief    : ROWS x COLS character buffer with cursor commands, clear/scroll
//            sweeps and an independent registered LCD-side read port.
// Revision : 1.0
// ============================================================================
module lcd_text_buffer #(
    parameter int         DATA_WIDTH  = 8,
    parameter int         COLS        = 16,
    parameter int         ROWS        = 2,
    parameter int         POS_BITS    = 5,
    parameter logic [7:0] BLANK       = 8'h20,
    parameter bit         AUTO_SCROLL = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    input  logic [2:0]            cmd,
    input  logic [POS_BITS-1:0]   pos,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  cmd_ready,
    output logic                  busy,
    output logic [POS_BITS-1:0]   cursor,
    input  logic [POS_BITS-1:0]   rd_pos,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH  = COLS * ROWS;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [DATA_WIDTH-1:0] BLANK_VAL     = DATA_WIDTH'(BLANK);
    localparam logic [POS_BITS-1:0]   LAST_POS      = POS_BITS'(DEPTH - 1);
    localparam logic [POS_BITS-1:0]   FILL_START    = POS_BITS'(DEPTH - COLS);
    localparam logic [POS_BITS-1:0]   COPY_LAST     = POS_BITS'(DEPTH - COLS - 1);
    localparam logic [POS_BITS-1:0]   SCROLL_CURSOR = POS_BITS'((ROWS - 1) * COLS);
    localparam logic [POS_BITS-1:0]   ONE           = POS_BITS'(1);

    localparam logic [2:0] CMD_WRITE_AT  = 3'd1;
    localparam logic [2:0] CMD_WRITE_CUR = 3'd2;
    localparam logic [2:0] CMD_SET_CUR   = 3'd3;
    localparam logic [2:0] CMD_CLEAR     = 3'd4;
    localparam logic [2:0] CMD_SCROLL    = 3'd5;
    localparam logic [2:0] CMD_HOME      = 3'd6;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_CLR      = 2'd1;
    localparam logic [1:0] S_SCR_COPY = 2'd2;
    localparam logic [1:0] S_SCR_FILL = 2'd3;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [POS_BITS-1:0]   idx;
    logic [POS_BITS-1:0]   idx_next;
    logic [POS_BITS-1:0]   cursor_next;
    logic                  scroll_pending;
    logic                  pending_next;
    logic                  accept;
    logic                  pos_ok;
    logic                  rd_ok;
    logic [POS_BITS-1:0]   copy_src;
    logic                  mem_we;
    logic [POS_BITS-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  adv;
    logic [POS_BITS-1:0]   adv_from;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // The auto-scroll gap cycle is IDLE but must still refuse commands.
    assign busy      = (state != S_IDLE) || scroll_pending;
    assign cmd_ready = !busy;
    assign accept    = cmd_valid && !busy;
    assign pos_ok    = int'(pos) < DEPTH;
    assign rd_ok     = int'(rd_pos) < DEPTH;
    assign copy_src  = POS_BITS'(int'(idx) + COLS);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= S_CLR;
            idx            <= '0;
            cursor         <= '0;
            scroll_pending <= 1'b0;
        end else begin
            state          <= state_next;
            idx            <= idx_next;
            cursor         <= cursor_next;
            scroll_pending <= pending_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            S_IDLE: begin
                if (scroll_pending || (accept && cmd == CMD_SCROLL)) begin
                    if (ROWS > 1) begin
                        state_next = S_SCR_COPY;
                        idx_next   = '0;
                    end else begin
                        state_next = S_SCR_FILL;
                        idx_next   = FILL_START;
                    end
                end else if (accept && cmd == CMD_CLEAR) begin
                    state_next = S_CLR;
                    idx_next   = '0;
                end
            end
            S_SCR_COPY: begin
                if (idx == COPY_LAST) begin
                    state_next = S_SCR_FILL;
                    idx_next   = FILL_START;
                end else begin
                    idx_next = idx + ONE;
                end
            end
            default: begin
                // CLR and SCR_FILL both end on the last cell; idx holds there.
                if (idx == LAST_POS) begin
                    state_next = S_IDLE;
                end else begin
                    idx_next = idx + ONE;
                end
            end
        endcase
    end

    always_comb begin
        mem_we       = 1'b0;
        mem_addr     = idx;
        mem_wdata    = BLANK_VAL;
        cursor_next  = cursor;
        pending_next = 1'b0;
        adv          = 1'b0;
        adv_from     = cursor;
        case (state)
            S_CLR, S_SCR_FILL: mem_we = 1'b1;
            S_SCR_COPY: begin
                mem_we    = 1'b1;
                mem_wdata = mem[ADDR_W'(copy_src)];
            end
            default: begin
                if (accept) begin
                    case (cmd)
                        CMD_WRITE_AT: begin
                            if (pos_ok) begin
                                mem_we    = 1'b1;
                                mem_addr  = pos;
                                mem_wdata = data;
                                adv       = 1'b1;
                                adv_from  = pos;
                            end
                        end
                        CMD_WRITE_CUR: begin
                            mem_we    = 1'b1;
                            mem_addr  = cursor;
                            mem_wdata = data;
                            adv       = 1'b1;
                        end
                        CMD_SET_CUR: begin
                            if (pos_ok) begin
                                cursor_next = pos;
                            end
                        end
                        CMD_HOME, CMD_CLEAR: cursor_next = '0;
                        default: ;
                    endcase
                end
            end
        endcase
        if (adv) begin
            if (adv_from == LAST_POS) begin
                if (AUTO_SCROLL) begin
                    cursor_next  = SCROLL_CURSOR;
                    pending_next = 1'b1;
                end else begin
                    cursor_next = '0;
                end
            end else begin
                cursor_next = adv_from + ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[ADDR_W'(mem_addr)] <= mem_wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data <= BLANK_VAL;
        end else begin
            rd_data <= rd_ok ? mem[ADDR_W'(rd_pos)] : BLANK_VAL;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_text_buffer.sv
`default_nettype none
// Directed bench: instance a wraps the cursor, instance b auto-scrolls; both are
// 2x16 with 6-bit positions so out-of-range addresses can be exercised.
module tb_lcd_text_buffer;

    localparam int PB = 6;
    localparam logic [2:0] WR_AT = 3'd1, WR_CUR = 3'd2, SET_CUR = 3'd3;
    localparam logic [2:0] CLEAR = 3'd4, SCROLL = 3'd5, HOME = 3'd6;

    logic          clock;
    logic          reset_a, valid_a, ready_a, busy_a;
    logic [2:0]    cmd_a;
    logic [PB-1:0] pos_a, rd_pos_a, cursor_a;
    logic [7:0]    data_a, rd_data_a;
    logic          reset_b, valid_b, ready_b, busy_b;
    logic [2:0]    cmd_b;
    logic [PB-1:0] pos_b, rd_pos_b, cursor_b;
    logic [7:0]    data_b, rd_data_b;

    int checks   = 0;
    int failures = 0;
    int n;

    lcd_text_buffer #(
        .DATA_WIDTH(8), .COLS(16), .ROWS(2), .POS_BITS(PB), .BLANK(8'h20), .AUTO_SCROLL(1'b0)
    ) dut_a (
        .clock(clock), .reset(reset_a), .cmd_valid(valid_a), .cmd(cmd_a), .pos(pos_a),
        .data(data_a), .cmd_ready(ready_a), .busy(busy_a), .cursor(cursor_a),
        .rd_pos(rd_pos_a), .rd_data(rd_data_a)
    );

    lcd_text_buffer #(
        .DATA_WIDTH(8), .COLS(16), .ROWS(2), .POS_BITS(PB), .BLANK(8'h20), .AUTO_SCROLL(1'b1)
    ) dut_b (
        .clock(clock), .reset(reset_b), .cmd_valid(valid_b), .cmd(cmd_b), .pos(pos_b),
        .data(data_b), .cmd_ready(ready_b), .busy(busy_b), .cursor(cursor_b),
        .rd_pos(rd_pos_b), .rd_data(rd_data_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, required finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic issue_a(input logic [2:0] c, input logic [PB-1:0] p, input logic [7:0] d);
        valid_a = 1'b1; cmd_a = c; pos_a = p; data_a = d;
        step();
        valid_a = 1'b0;
    endtask

    task automatic read_a(input logic [PB-1:0] p, input logic [7:0] exp, input string tag);
        rd_pos_a = p;
        step();
        check(tag, 32'(rd_data_a), 32'(exp));
    endtask

    task automatic read_b(input logic [PB-1:0] p, input logic [7:0] exp, input string tag);
        rd_pos_b = p;
        step();
        check(tag, 32'(rd_data_b), 32'(exp));
    endtask

    // Counts sampled cycles with busy high, starting at the current sample.
    task automatic wait_idle_a(output int cnt);
        cnt = 0;
        while (busy_a && cnt < 200) begin
            cnt++;
            step();
        end
    endtask

    task automatic wait_idle_b(output int cnt);
        cnt = 0;
        while (busy_b && cnt < 200) begin
            cnt++;
            step();
        end
    endtask

    initial begin
        reset_a = 1'b1; valid_a = 1'b0; cmd_a = '0; pos_a = '0; data_a = '0; rd_pos_a = 6'd40;
        reset_b = 1'b1; valid_b = 1'b0; cmd_b = '0; pos_b = '0; data_b = '0; rd_pos_b = '0;

        step();
        check("reset_busy", 32'(busy_a), 32'd1);
        check("reset_ready", 32'(ready_a), 32'd0);
        check("reset_cursor", 32'(cursor_a), 32'd0);
        check("reset_rd_data", 32'(rd_data_a), 32'h20);
        step();
        step();
        reset_a = 1'b0;
        reset_b = 1'b0;
        wait_idle_a(n);
        check("release_busy_cycles", 32'(n), 32'd32);
        check("release_cursor", 32'(cursor_a), 32'd0);
        check("b_idle_after_release", 32'(busy_b), 32'd0);
        for (int i = 0; i < 32; i++) read_a(PB'(i), 8'h20, "init_blank");

        // Positional write with a same-cycle read of the target cell.
        rd_pos_a = 6'd5;
        issue_a(WR_AT, 6'd5, 8'h41);
        check("same_cycle_read_old", 32'(rd_data_a), 32'h20);
        check("write_at_cursor", 32'(cursor_a), 32'd6);
        step();
        check("write_at_visible", 32'(rd_data_a), 32'h41);

        // Cursor wrap without auto-scroll.
        issue_a(SET_CUR, 6'd30, 8'h00);
        check("set_cur_30", 32'(cursor_a), 32'd30);
        issue_a(WR_CUR, 6'd0, 8'h58);
        check("wr_cur_adv", 32'(cursor_a), 32'd31);
        check("wr_cur_busy0", 32'(busy_a), 32'd0);
        issue_a(WR_CUR, 6'd0, 8'h59);
        check("wr_cur_wrap", 32'(cursor_a), 32'd0);
        check("wr_cur_wrap_busy0", 32'(busy_a), 32'd0);
        step();
        check("wrap_no_busy", 32'(busy_a), 32'd0);
        read_a(6'd30, 8'h58, "cell30");
        read_a(6'd31, 8'h59, "cell31");

        // Out-of-range positions are ignored; HOME returns to zero.
        issue_a(SET_CUR, 6'd7, 8'h00);
        issue_a(SET_CUR, 6'd40, 8'h00);
        check("set_cur_oob", 32'(cursor_a), 32'd7);
        issue_a(WR_AT, 6'd33, 8'h77);
        check("write_at_oob", 32'(cursor_a), 32'd7);
        issue_a(HOME, 6'd0, 8'h00);
        check("home", 32'(cursor_a), 32'd0);
        issue_a(WR_AT, 6'd12, 8'h66);
        check("write_at_12", 32'(cursor_a), 32'd13);

        // Clear with a write attempted while busy.
        issue_a(CLEAR, 6'd0, 8'h00);
        check("clear_busy", 32'(busy_a), 32'd1);
        check("clear_ready", 32'(ready_a), 32'd0);
        check("clear_cursor", 32'(cursor_a), 32'd0);
        valid_a = 1'b1; cmd_a = WR_AT; pos_a = 6'd3; data_a = 8'h55;
        step();
        valid_a = 1'b0;
        check("busy_drop_ready", 32'(ready_a), 32'd0);
        wait_idle_a(n);
        check("clear_remaining_busy", 32'(n), 32'd31);
        check("clear_done_ready", 32'(ready_a), 32'd1);
        read_a(6'd3, 8'h20, "dropped_write");
        read_a(6'd12, 8'h20, "cleared_12");
        read_a(6'd5, 8'h20, "cleared_5");
        check("clear_cursor_after", 32'(cursor_a), 32'd0);

        // Full manual scroll.
        issue_a(WR_AT, 6'd20, 8'h61);
        issue_a(WR_AT, 6'd2, 8'h62);
        issue_a(SCROLL, 6'd0, 8'h00);
        check("scroll_busy", 32'(busy_a), 32'd1);
        wait_idle_a(n);
        check("scroll_busy_cycles", 32'(n), 32'd32);
        check("scroll_cursor_kept", 32'(cursor_a), 32'd3);
        read_a(6'd4, 8'h61, "scroll_moved");
        read_a(6'd20, 8'h20, "scroll_filled");
        read_a(6'd2, 8'h20, "scroll_overwrote");

        // Reset in the 10th copy cycle of a scroll.
        issue_a(WR_AT, 6'd17, 8'h33);
        issue_a(WR_AT, 6'd1, 8'h34);
        rd_pos_a = 6'd40;
        issue_a(SCROLL, 6'd0, 8'h00);
        for (int i = 0; i < 9; i++) step();
        check("mid_scroll_busy", 32'(busy_a), 32'd1);
        reset_a = 1'b1;
        #1;
        check("mid_reset_busy", 32'(busy_a), 32'd1);
        check("mid_reset_cursor", 32'(cursor_a), 32'd0);
        check("mid_reset_rd40", 32'(rd_data_a), 32'h20);
        step();
        step();
        reset_a = 1'b0;
        wait_idle_a(n);
        check("restart_clear_cycles", 32'(n), 32'd32);
        check("restart_rd40", 32'(rd_data_a), 32'h20);
        check("restart_cursor", 32'(cursor_a), 32'd0);
        for (int i = 0; i < 32; i++) read_a(PB'(i), 8'h20, "restart_blank");

        // Auto-scroll on cursor overflow.
        for (int i = 0; i < 32; i++) begin
            valid_b = 1'b1; cmd_b = WR_CUR; data_b = (i < 16) ? 8'h41 : 8'h42;
            step();
            if (i < 31) check("fill_b_not_busy", 32'(busy_b), 32'd0);
        end
        valid_b = 1'b0;
        check("auto_cursor", 32'(cursor_b), 32'd16);
        check("auto_busy", 32'(busy_b), 32'd1);
        wait_idle_b(n);
        check("auto_busy_cycles", 32'(n), 32'd33);
        check("auto_cursor_after", 32'(cursor_b), 32'd16);
        for (int i = 0; i < 16; i++) read_b(PB'(i), 8'h42, "auto_row0");
        for (int i = 16; i < 32; i++) read_b(PB'(i), 8'h20, "auto_row1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
